// File: rtl/morse_pkg.sv
// Shared definitions for the Morse family: letter codes, widths, FSM states
// and the helper that expands a dot/dash description into a keying pattern.
package morse_pkg;

  localparam int LETTER_W = 5;
  localparam int LEN_W    = 5;
  localparam int MAX_LEN  = 14;

  localparam logic [LETTER_W-1:0]
    L_A = 5'd0,  L_B = 5'd1,  L_C = 5'd2,  L_D = 5'd3,  L_E = 5'd4,
    L_F = 5'd5,  L_G = 5'd6,  L_H = 5'd7,  L_I = 5'd8,  L_J = 5'd9,
    L_K = 5'd10, L_L = 5'd11, L_M = 5'd12, L_N = 5'd13, L_O = 5'd14,
    L_P = 5'd15, L_Q = 5'd16, L_R = 5'd17, L_S = 5'd18, L_T = 5'd19,
    L_U = 5'd20, L_V = 5'd21, L_W = 5'd22, L_X = 5'd23, L_Y = 5'd24,
    L_Z = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Left-aligned keying pattern plus the number of emitted units.
  typedef struct packed {
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
  } sym_t;

  // n_el elements, first element in dashes[3]; 1 = dash ("1110"), 0 = dot ("10").
  // Every element carries its own trailing one-unit gap.
  function automatic sym_t build_sym(input logic [2:0] n_el, input logic [3:0] dashes);
    sym_t               s;
    logic [MAX_LEN-1:0] p;
    logic [LEN_W-1:0]   l;
    p = '0;
    l = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(n_el)) begin
        if (dashes[3-k]) begin
          p = {p[MAX_LEN-5:0], 4'b1110};
          l = l + LEN_W'(4);
        end else begin
          p = {p[MAX_LEN-3:0], 2'b10};
          l = l + LEN_W'(2);
        end
      end
    end
    // Move the right-packed elements up so the first unit sits in the MSB.
    p = p << (MAX_LEN - int'(l));
    s.pat = p;
    s.len = l;
    return s;
  endfunction

endpackage

// File: rtl/morse_encoder_seq_if.sv
// Start/busy/done handshake plus keyed output between a letter sequencer
// (master) and the encoder (slave).
interface morse_encoder_seq_if;
  import morse_pkg::*;

  logic [LETTER_W-1:0] letter;
  logic                start;
  logic                morse_code;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output letter, start,
    input  morse_code, busy, done, err
  );

  modport slave (
    input  letter, start,
    output morse_code, busy, done, err
  );

endinterface

// File: rtl/morse_lookup_az.sv
// Combinational A..Z table: letter code -> left-aligned keying pattern,
// unit count (including the trailing element gap) and a valid flag.
module morse_lookup_az
  import morse_pkg::*;
#(
  parameter int PAT_W = 16   // must be >= MAX_LEN
) (
  input  logic [LETTER_W-1:0] i_letter,
  output logic [PAT_W-1:0]    o_pattern,
  output logic [LEN_W-1:0]    o_len,
  output logic                o_valid
);

  sym_t w_sym;

  // Table entries are written as element count plus dash mask, read left to right.
  always_comb begin
    w_sym   = '0;
    o_valid = 1'b1;
    case (i_letter)
      L_A: w_sym = build_sym(3'd2, 4'b0100);  // .-
      L_B: w_sym = build_sym(3'd4, 4'b1000);  // -...
      L_C: w_sym = build_sym(3'd4, 4'b1010);  // -.-.
      L_D: w_sym = build_sym(3'd3, 4'b1000);  // -..
      L_E: w_sym = build_sym(3'd1, 4'b0000);  // .
      L_F: w_sym = build_sym(3'd4, 4'b0010);  // ..-.
      L_G: w_sym = build_sym(3'd3, 4'b1100);  // --.
      L_H: w_sym = build_sym(3'd4, 4'b0000);  // ....
      L_I: w_sym = build_sym(3'd2, 4'b0000);  // ..
      L_J: w_sym = build_sym(3'd4, 4'b0111);  // .---
      L_K: w_sym = build_sym(3'd3, 4'b1010);  // -.-
      L_L: w_sym = build_sym(3'd4, 4'b0100);  // .-..
      L_M: w_sym = build_sym(3'd2, 4'b1100);  // --
      L_N: w_sym = build_sym(3'd2, 4'b1000);  // -.
      L_O: w_sym = build_sym(3'd3, 4'b1110);  // ---
      L_P: w_sym = build_sym(3'd4, 4'b0110);  // .--.
      L_Q: w_sym = build_sym(3'd4, 4'b1101);  // --.-
      L_R: w_sym = build_sym(3'd3, 4'b0100);  // .-.
      L_S: w_sym = build_sym(3'd3, 4'b0000);  // ...
      L_T: w_sym = build_sym(3'd1, 4'b1000);  // -
      L_U: w_sym = build_sym(3'd3, 4'b0010);  // ..-
      L_V: w_sym = build_sym(3'd4, 4'b0001);  // ...-
      L_W: w_sym = build_sym(3'd3, 4'b0110);  // .--
      L_X: w_sym = build_sym(3'd4, 4'b1001);  // -..-
      L_Y: w_sym = build_sym(3'd4, 4'b1011);  // -.--
      L_Z: w_sym = build_sym(3'd4, 4'b1100);  // --..
      default: o_valid = 1'b0;
    endcase
  end

  // Widen to the register width, keeping the first unit in the MSB.
  assign o_pattern = PAT_W'(w_sym.pat) << (PAT_W - MAX_LEN);
  assign o_len     = w_sym.len;

endmodule

// File: rtl/morse_encoder_seq.sv
// One-shot Morse letter encoder: keys the pattern of an accepted letter,
// appends GAP_UNITS silent units, then pulses done and returns to idle so
// a sequencer can chain letters on consecutive cycles.
module morse_encoder_seq
  import morse_pkg::*;
#(
  parameter int CLK_DIV   = 25000000,  // clocks per Morse unit, >= 1
  parameter int CNT_W     = 26,        // 2**CNT_W > CLK_DIV
  parameter int PAT_W     = 16,        // >= MAX_LEN
  parameter int GAP_UNITS = 2          // extra silent units after the pattern
) (
  input  logic                clock,
  input  logic                reset,
  morse_encoder_seq_if.slave  bus
);

  localparam int               GAP_W     = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_UNITS > 0) ? GAP_UNITS - 1 : 0);
  localparam bit               HAS_GAP   = (GAP_UNITS > 0);

  state_t             r_state, w_state_next;
  logic [PAT_W-1:0]   r_pat, w_pat_next;
  logic [LEN_W-1:0]   r_left, w_left_next;          // pattern units still to finish, minus one
  logic [CNT_W-1:0]   r_tick, w_tick_next;          // clocks left in the current unit, minus one
  logic [GAP_W-1:0]   r_gap_left, w_gap_left_next;  // gap units still to finish, minus one
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               r_err, w_err_next;

  logic [PAT_W-1:0]   w_lk_pattern;
  logic [LEN_W-1:0]   w_lk_len;
  logic               w_lk_valid;
  logic               w_unit_end;

  morse_lookup_az #(
    .PAT_W (PAT_W)
  ) u_lookup (
    .i_letter  (bus.letter),
    .o_pattern (w_lk_pattern),
    .o_len     (w_lk_len),
    .o_valid   (w_lk_valid)
  );

  assign w_unit_end = (r_tick == '0);

  // Next-state logic: accept/reject in IDLE, unit pacing in SEND and GAP.
  always_comb begin
    w_state_next    = r_state;
    w_pat_next      = r_pat;
    w_left_next     = r_left;
    w_tick_next     = r_tick;
    w_gap_left_next = r_gap_left;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_lk_valid) begin
            // Restart the unit counter here so the first unit is full length.
            w_state_next = ST_SEND;
            w_pat_next   = w_lk_pattern;
            w_left_next  = w_lk_len - LEN_W'(1);
            w_tick_next  = TICK_LOAD;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (w_unit_end) begin
          w_tick_next = TICK_LOAD;
          // Shifting on the final unit too leaves the register all-zero,
          // which is exactly the silent output wanted for the gap and idle.
          w_pat_next  = r_pat << 1;
          if (r_left == '0) begin
            if (HAS_GAP) begin
              w_state_next    = ST_GAP;
              w_gap_left_next = GAP_LOAD;
            end else begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
            end
          end else begin
            w_left_next = r_left - LEN_W'(1);
          end
        end else begin
          w_tick_next = r_tick - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (w_unit_end) begin
          w_tick_next = TICK_LOAD;
          if (r_gap_left == '0) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_gap_left_next = r_gap_left - GAP_W'(1);
          end
        end else begin
          w_tick_next = r_tick - CNT_W'(1);
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  // State and output registers; reset aborts any letter without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pat      <= '0;
      r_left     <= '0;
      r_tick     <= '0;
      r_gap_left <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pat      <= w_pat_next;
      r_left     <= w_left_next;
      r_tick     <= w_tick_next;
      r_gap_left <= w_gap_left_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
    end
  end

  assign bus.morse_code = r_pat[PAT_W-1];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_morse_encoder_seq.sv
// Bench for morse_encoder_seq: two instances (4 clk/unit with 2 gap units,
// and 1 clk/unit with no gap) checked every cycle against a model that
// expands dot/dash strings into per-cycle output queues.
module tb_morse_encoder_seq;

  localparam int DIV_A = 4, GAP_A = 2;
  localparam int DIV_B = 1, GAP_B = 0;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  morse_encoder_seq_if ifa();
  morse_encoder_seq_if ifb();

  morse_encoder_seq #(.CLK_DIV(DIV_A), .CNT_W(4), .PAT_W(16), .GAP_UNITS(GAP_A)) dut_a (
    .clock (clk), .reset (rst_a), .bus (ifa)
  );
  morse_encoder_seq #(.CLK_DIV(DIV_B), .CNT_W(4), .PAT_W(16), .GAP_UNITS(GAP_B)) dut_b (
    .clock (clk), .reset (rst_b), .bus (ifb)
  );

  always #5 clk = ~clk;

  string tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  // Per-cycle keyed output for one letter: dot = 1 on unit, dash = 3 on units,
  // each followed by one off unit, then the letter gap.
  function automatic bitq_t build_seq(int lt, int div, int gap);
    bitq_t q;
    string s;
    s = tbl[lt];
    for (int i = 0; i < s.len(); i++) begin
      int on_units;
      on_units = (s.getc(i) == "-") ? 3 : 1;
      repeat (on_units * div) q.push_back(1'b1);
      repeat (div) q.push_back(1'b0);
    end
    repeat (gap * div) q.push_back(1'b0);
    return q;
  endfunction

  function automatic logic [63:0] pack(bitq_t q);
    logic [63:0] v;
    v = '0;
    foreach (q[i]) v = {v[62:0], q[i]};
    return v;
  endfunction

  task automatic check(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bitq_t mq [2];
  bit exp_morse [2], exp_busy [2], exp_done [2], exp_err [2];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int m = 0; m < 2; m++) begin
      bit st, rs, prev_busy;
      int lt;
      st = (m == 0) ? ifa.start : ifb.start;
      rs = (m == 0) ? rst_a : rst_b;
      lt = (m == 0) ? int'(ifa.letter) : int'(ifb.letter);
      if (rs) begin
        mq[m].delete();
        exp_morse[m] = 1'b0; exp_busy[m] = 1'b0; exp_done[m] = 1'b0; exp_err[m] = 1'b0;
      end else begin
        prev_busy = exp_busy[m];
        exp_err[m] = 1'b0;
        if (st && !prev_busy) begin
          if (lt < 26) mq[m] = build_seq(lt, (m == 0) ? DIV_A : DIV_B, (m == 0) ? GAP_A : GAP_B);
          else exp_err[m] = 1'b1;
        end
        if (mq[m].size() > 0) begin
          exp_morse[m] = mq[m].pop_front();
          exp_busy[m]  = 1'b1;
        end else begin
          exp_morse[m] = 1'b0;
          exp_busy[m]  = 1'b0;
        end
        exp_done[m] = prev_busy && !exp_busy[m];
      end
    end
  end

  // ---------------- compare + activity statistics ----------------
  int done_cnt [2], last_done [2], err_cnt [2], last_err [2], ones_cnt [2], busy_cnt [2];
  int s_done [2], s_err [2], s_ones [2], s_busy [2];

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int m = 0; m < 2; m++) begin
        bit a_m, a_b, a_d, a_e;
        string id;
        id  = (m == 0) ? "A" : "B";
        a_m = (m == 0) ? ifa.morse_code : ifb.morse_code;
        a_b = (m == 0) ? ifa.busy : ifb.busy;
        a_d = (m == 0) ? ifa.done : ifb.done;
        a_e = (m == 0) ? ifa.err : ifb.err;
        check($sformatf("%s.morse@%0d", id, cyc), a_m, exp_morse[m]);
        check($sformatf("%s.busy@%0d", id, cyc), a_b, exp_busy[m]);
        check($sformatf("%s.done@%0d", id, cyc), a_d, exp_done[m]);
        check($sformatf("%s.err@%0d", id, cyc), a_e, exp_err[m]);
        if (a_d) begin done_cnt[m]++; last_done[m] = cyc; end
        if (a_e) begin err_cnt[m]++;  last_err[m]  = cyc; end
        if (a_m) ones_cnt[m]++;
        if (a_b) busy_cnt[m]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(int m, bit st, logic [4:0] lt);
    if (m == 0) begin ifa.start = st; ifa.letter = lt; end
    else        begin ifb.start = st; ifb.letter = lt; end
  endtask

  task automatic wait_until(int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Start held for exactly one cycle (cycle 'target'); letter then changes
  // to show it is only sampled at acceptance.
  task automatic pulse_at(int m, int lt, int target);
    wait_until(target);
    drive(m, 1'b1, 5'(lt));
    @(negedge clk);
    drive(m, 1'b0, 5'd25);
  endtask

  task automatic snap(int m);
    s_done[m] = done_cnt[m]; s_err[m] = err_cnt[m];
    s_ones[m] = ones_cnt[m]; s_busy[m] = busy_cnt[m];
  endtask

  task automatic verify(string nm, int m, int d_done, int l_done, int d_ones,
                        int d_busy, int d_err, int l_err);
    check({nm, ".done_pulses"}, done_cnt[m] - s_done[m], d_done);
    if (d_done > 0) check({nm, ".done_cycle"}, last_done[m], l_done);
    check({nm, ".on_cycles"},   ones_cnt[m] - s_ones[m], d_ones);
    check({nm, ".busy_cycles"}, busy_cnt[m] - s_busy[m], d_busy);
    check({nm, ".err_pulses"},  err_cnt[m] - s_err[m], d_err);
    if (d_err > 0) check({nm, ".err_cycle"}, last_err[m], l_err);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bitq_t tq;
    int t0;
    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 5'd0);
    drive(1, 1'b0, 5'd0);

    // Model pins against hand-expanded patterns.
    tq = build_seq(4, DIV_A, GAP_A);   check("pin.E4.len", tq.size(), 16); check("pin.E4.bits", pack(tq), 64'hF000);
    tq = build_seq(19, DIV_A, GAP_A);  check("pin.T4.len", tq.size(), 24); check("pin.T4.bits", pack(tq), 64'hFFF000);
    tq = build_seq(0, DIV_B, GAP_B);   check("pin.A1.len", tq.size(), 6);  check("pin.A1.bits", pack(tq), 64'h2E);
    tq = build_seq(24, DIV_B, GAP_B);  check("pin.Y1.len", tq.size(), 14); check("pin.Y1.bits", pack(tq), 64'h3AEE);
    tq = build_seq(9, DIV_B, GAP_B);   check("pin.J1.len", tq.size(), 14); check("pin.J1.bits", pack(tq), 64'h2EEE);

    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // E: on 1..4, busy 1..16, done at 17.
    snap(0); t0 = cyc; pulse_at(0, 4, t0); wait_until(t0 + 20);
    verify("A.E", 0, 1, t0 + 17, 4, 16, 0, -1);

    // T: on 1..12, busy 24 cycles.
    snap(0); t0 = cyc; pulse_at(0, 19, t0); wait_until(t0 + 28);
    verify("A.T", 0, 1, t0 + 25, 12, 24, 0, -1);

    // Invalid letter: one err pulse, nothing else.
    snap(0); t0 = cyc; pulse_at(0, 27, t0); wait_until(t0 + 4);
    verify("A.bad27", 0, 0, -1, 0, 0, 1, t0 + 1);

    // A after the error: (1+3) on units, (6+2)*4 busy.
    snap(0); t0 = cyc; pulse_at(0, 0, t0); wait_until(t0 + 36);
    verify("A.A", 0, 1, t0 + 33, 16, 32, 0, -1);

    // S, ignored mid-letter start, S again in the done cycle.
    snap(0); t0 = cyc;
    pulse_at(0, 18, t0);
    pulse_at(0, 25, t0 + 10);
    pulse_at(0, 18, t0 + 33);
    wait_until(t0 + 70);
    verify("A.SS", 0, 2, t0 + 66, 24, 64, 0, -1);

    // Y aborted by reset in cycle 6, then a full Y.
    snap(0); t0 = cyc; pulse_at(0, 24, t0);
    wait_until(t0 + 6);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    wait_until(t0 + 12);
    verify("A.Yabort", 0, 0, -1, 6, 6, 0, -1);
    snap(0); t0 = cyc; pulse_at(0, 24, t0); wait_until(t0 + 70);
    verify("A.Y", 0, 1, t0 + 65, 40, 64, 0, -1);

    // One clock per unit, no gap.
    snap(1); t0 = cyc; pulse_at(1, 4, t0); wait_until(t0 + 6);
    verify("B.E", 1, 1, t0 + 3, 1, 2, 0, -1);
    snap(1); t0 = cyc; pulse_at(1, 24, t0); wait_until(t0 + 18);
    verify("B.Y", 1, 1, t0 + 15, 10, 14, 0, -1);
    snap(1); t0 = cyc; pulse_at(1, 31, t0); wait_until(t0 + 4);
    verify("B.bad31", 1, 0, -1, 0, 0, 1, t0 + 1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
